rc_seq: RTL

RC_SEQ -- requirements
Module: rc_seq

---
 rtl/rc_seq_pkg.sv | 16 +
 rtl/rc_seq_if.sv | 36 +++
 rtl/rc_seq_rc.sv | 13 +
 rtl/rc_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/rc_seq_pkg.sv
// rc_seq_pkg: shared definitions for the bit-serial AND/OR sequencer.
//   N_DEFAULT  default operand width
//   OP_CNT_W   width of the completed-operation counter
//   state_t    sequencer state encoding (IDLE, RUN, DONE)
package rc_seq_pkg;

   localparam int N_DEFAULT = 8;
   localparam int OP_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rc_seq_if.sv
// rc_seq_if: operand/result handshake bundle for rc_seq.
//   in_valid/in_ready/a/b        operand channel (producer -> block)
//   and_out/or_out/out_valid/out_ready  result channel (block -> consumer)
//   busy, op_count               status
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid is never withdrawn by the block once raised; the producer
// holds in_valid/a/b until it sees in_ready, and the block holds
// out_valid/and_out/or_out stable until the edge where out_ready is 1.
interface rc_seq_if
   import rc_seq_pkg::*;
#(
   parameter int N = N_DEFAULT
);
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0]        a;
   logic [N-1:0]        b;
   logic [N-1:0]        and_out;
   logic [N-1:0]        or_out;
   logic                out_valid;
   logic                out_ready;
   logic                busy;
   logic [OP_CNT_W-1:0] op_count;

   // master: producer/consumer environment
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, and_out, or_out, out_valid, busy, op_count
   );

   // slave: the rc_seq block
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, and_out, or_out, out_valid, busy, op_count
   );
endinterface

// File: rtl/rc_seq_rc.sv
// rc: single-bit AND/OR cell.
//   x, y  input bits
//   w     x AND y
//   z     x OR y
module rc (
   input  logic x,
   input  logic y,
   output logic w,
   output logic z
);
   assign w = x & y;
   assign z = x | y;
endmodule

// File: rtl/rc_seq.sv
// rc_seq: bit-serial AND/OR of two N-bit operands using one rc cell,
// one bit per clock, LSB first.
//   clock   rising-edge clock
//   reset_  synchronous active-low reset
//   bus     rc_seq_if slave: operand and result handshakes, busy, op_count
//   state   current sequencer state (debug visibility)
module rc_seq
   import rc_seq_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic    clock,
   input  logic    reset_,
   rc_seq_if.slave bus,
   output state_t  state
);
   localparam int CW = $clog2(N);

   state_t              state_r;
   logic [CW-1:0]       bit_cnt;
   logic [N-1:0]        a_sr;
   logic [N-1:0]        b_sr;
   logic [N-1:0]        and_r;
   logic [N-1:0]        or_r;
   logic [OP_CNT_W-1:0] op_cnt;
   logic                in_ready_r;
   logic                busy_r;
   logic                out_valid_r;
   logic                w;
   logic                z;

   // The one shared cell always sees the current LSBs; its outputs are only
   // captured while in RUN.
   rc u_rc (
      .x (a_sr[0]),
      .y (b_sr[0]),
      .w (w),
      .z (z)
   );

   always_ff @(posedge clock) begin
      if (!reset_) begin
         state_r     <= IDLE;
         bit_cnt     <= '0;
         a_sr        <= '0;
         b_sr        <= '0;
         and_r       <= '0;
         or_r        <= '0;
         op_cnt      <= '0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr       <= bus.a;
                  b_sr       <= bus.b;
                  bit_cnt    <= '0;
                  state_r    <= RUN;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               // Results fill from the MSB so that after N steps bit i
               // lines up with operand bit i.
               and_r   <= {w, and_r[N-1:1]};
               or_r    <= {z, or_r[N-1:1]};
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == CW'(N - 1)) begin
                  state_r     <= DONE;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  op_cnt      <= op_cnt + OP_CNT_W'(1);
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.busy      = busy_r;
   assign bus.out_valid = out_valid_r;
   assign bus.and_out   = and_r;
   assign bus.or_out    = or_r;
   assign bus.op_count  = op_cnt;
   assign state         = state_r;

endmodule
